// File: rtl/filt_dec_rnd.sv
// filt_dec_rnd: integrate-and-dump decimator, averages 2**gp_dec_log2 samples per frame
// with optional round-half-up and saturation to the output width.
module filt_dec_rnd #(
  parameter int gp_inp_width = 16,
  parameter int gp_oup_width = 16,
  parameter int gp_dec_log2  = 2,
  parameter bit gp_rnd_mode  = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_an,
  input  logic                           i_ena,
  input  logic                           i_sync,
  input  logic signed [gp_inp_width-1:0] i_data,
  output logic signed [gp_oup_width-1:0] o_data,
  output logic                           o_rdy,
  output logic                           o_ovf
);
  localparam int L  = gp_dec_log2;
  localparam int AW = gp_inp_width + L;
  localparam int EW = (gp_oup_width > AW + 1) ? gp_oup_width : AW + 1;
  localparam logic [AW:0] c_rnd = gp_rnd_mode ? (AW + 1)'(1) << (L - 1) : '0;
  localparam logic signed [EW-1:0] c_max = {{(EW - gp_oup_width + 1){1'b0}}, {(gp_oup_width - 1){1'b1}}};
  localparam logic signed [EW-1:0] c_min = {{(EW - gp_oup_width + 1){1'b1}}, {(gp_oup_width - 1){1'b0}}};

  logic        [L-1:0]            r_cnt;
  logic signed [AW-1:0]           r_acc;
  logic signed [gp_oup_width-1:0] r_data;
  logic                           r_rdy;
  logic                           r_ovf;
  logic signed [AW-1:0]           w_sum;
  logic signed [AW:0]             w_ext;
  logic signed [AW:0]             w_shr;
  logic signed [EW-1:0]           w_rx;
  logic                           w_hi;
  logic                           w_lo;
  logic signed [gp_oup_width-1:0] w_sat;

  assign w_sum = r_acc + AW'(i_data);
  // one guard bit so the rounding offset cannot wrap a full-scale sum
  assign w_ext = {w_sum[AW-1], w_sum} + c_rnd;
  assign w_shr = w_ext >>> L;
  assign w_rx  = EW'(w_shr);
  assign w_hi  = w_rx > c_max;
  assign w_lo  = w_rx < c_min;
  assign w_sat = w_hi ? c_max[gp_oup_width-1:0] : w_lo ? c_min[gp_oup_width-1:0] : w_rx[gp_oup_width-1:0];

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_data <= '0;
      r_rdy  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (i_ena) begin
        if (i_sync) begin
          r_acc <= AW'(i_data);
          r_cnt <= L'(1);
        end else if (&r_cnt) begin
          r_data <= w_sat;
          r_ovf  <= w_hi | w_lo;
          r_rdy  <= 1'b1;
          r_acc  <= '0;
          r_cnt  <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + L'(1);
        end
      end
    end
  end

  assign o_data = r_data;
  assign o_rdy  = r_rdy;
  assign o_ovf  = r_ovf;
endmodule

// File: tb/tb_filt_dec_rnd.sv
// tb_filt_dec_rnd: three decimator variants (round/16b, truncate/16b, round/8b) on shared
// stimulus, checked against a frame-queue reference model and a table of hand-derived frames.
module tb_filt_dec_rnd;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic sync = 1'b0;
  logic signed [15:0] data = '0;
  logic signed [15:0] a_d, t_d;
  logic signed [7:0]  s_d;
  logic a_r, a_o, t_r, t_o, s_r, s_o;

  filt_dec_rnd #(.gp_inp_width(16), .gp_oup_width(16), .gp_dec_log2(2), .gp_rnd_mode(1'b1)) dut_a (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sync(sync), .i_data(data),
    .o_data(a_d), .o_rdy(a_r), .o_ovf(a_o));
  filt_dec_rnd #(.gp_inp_width(16), .gp_oup_width(16), .gp_dec_log2(2), .gp_rnd_mode(1'b0)) dut_t (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sync(sync), .i_data(data),
    .o_data(t_d), .o_rdy(t_r), .o_ovf(t_o));
  filt_dec_rnd #(.gp_inp_width(16), .gp_oup_width(8), .gp_dec_log2(2), .gp_rnd_mode(1'b1)) dut_s (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sync(sync), .i_data(data),
    .o_data(s_d), .o_rdy(s_r), .o_ovf(s_o));

  always #5 clk = ~clk;

  typedef struct {
    int x0, x1, x2, x3;
    int ea, et, es;
    bit os;
  } vec_t;

  vec_t tbl[$];
  int   q[$];
  int   e_d[3];
  bit   e_o[3];
  bit   e_rdy;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fdiv(input int s);
    return (s >= 0) ? s / N : -((-s + N - 1) / N);
  endfunction

  task automatic calc(input int sum, input int ow, input bit rnd, output int d, output bit o);
    int r, mx, mn;
    r  = fdiv(sum + (rnd ? N / 2 : 0));
    mx = (1 << (ow - 1)) - 1;
    mn = -(1 << (ow - 1));
    o  = (r > mx) || (r < mn);
    d  = (r > mx) ? mx : (r < mn) ? mn : r;
  endtask

  task automatic model_reset();
    q.delete();
    e_rdy = 1'b0;
    foreach (e_d[i]) begin
      e_d[i] = 0;
      e_o[i] = 1'b0;
    end
  endtask

  task automatic model(input bit e, input bit s, input int d);
    e_rdy = 1'b0;
    if (e) begin
      if (s) q.delete();
      q.push_back(d);
      if (!s && q.size() == N) begin
        calc(q.sum(), 16, 1'b1, e_d[0], e_o[0]);
        calc(q.sum(), 16, 1'b0, e_d[1], e_o[1]);
        calc(q.sum(), 8,  1'b1, e_d[2], e_o[2]);
        q.delete();
        e_rdy = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("rdy_rnd16", int'(a_r), int'(e_rdy));
    chk("dat_rnd16", int'(a_d), e_d[0]);
    chk("ovf_rnd16", int'(a_o), int'(e_o[0]));
    chk("rdy_trn16", int'(t_r), int'(e_rdy));
    chk("dat_trn16", int'(t_d), e_d[1]);
    chk("ovf_trn16", int'(t_o), int'(e_o[1]));
    chk("rdy_rnd8", int'(s_r), int'(e_rdy));
    chk("dat_rnd8", int'(s_d), e_d[2]);
    chk("ovf_rnd8", int'(s_o), int'(e_o[2]));
  endtask

  task automatic step(input bit e, input bit s, input int d);
    ena  = e;
    sync = s;
    data = 16'(d);
    @(posedge clk);
    model(e, s, d);
    #1;
    check_all();
  endtask

  task automatic add(input int x0, x1, x2, x3, ea, et, es, input bit os);
    vec_t v;
    v = '{x0: x0, x1: x1, x2: x2, x3: x3, ea: ea, et: et, es: es, os: os};
    tbl.push_back(v);
  endtask

  initial begin
    int hold, d, m;
    bit e, s;
    add(100, 100, 100, 100, 100, 100, 100, 1'b0);
    add(1, 1, 1, 0, 1, 0, 1, 1'b0);
    add(-1, -1, 0, 0, 0, -1, 0, 1'b0);
    add(-1, -1, -1, -1, -1, -1, -1, 1'b0);
    add(200, 200, 200, 200, 200, 200, 127, 1'b1);
    add(-300, -300, -300, -300, -300, -300, -128, 1'b1);
    add(5, 5, 5, 5, 5, 5, 5, 1'b0);
    add(32767, 32767, 32767, 32767, 32767, 32767, 127, 1'b1);
    add(-32768, -32768, -32768, -32768, -32768, -32768, -128, 1'b1);
    add(1, 2, 3, 4, 3, 2, 3, 1'b0);
    add(-1, -2, -3, -4, -2, -3, -2, 1'b0);

    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 100);
      chk("t1_rdy", int'(a_r), (i % 4 == 0) ? 1 : 0);
    end
    chk("t1_dat", int'(a_d), 100);

    foreach (tbl[i]) begin
      step(1'b1, 1'b0, tbl[i].x0);
      step(1'b1, 1'b0, tbl[i].x1);
      step(1'b1, 1'b0, tbl[i].x2);
      step(1'b1, 1'b0, tbl[i].x3);
      chk("tbl_rdy", int'(a_r), 1);
      chk("tbl_rnd16", int'(a_d), tbl[i].ea);
      chk("tbl_trn16", int'(t_d), tbl[i].et);
      chk("tbl_rnd8", int'(s_d), tbl[i].es);
      chk("tbl_ovf8", int'(s_o), int'(tbl[i].os));
      chk("tbl_ovf16", int'(a_o), 0);
    end

    hold = int'(a_d);
    step(1'b1, 1'b0, 8);
    step(1'b1, 1'b0, 8);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0], int'($urandom_range(1000)));
      chk("gap_rdy", int'(a_r), 0);
      chk("gap_hold", int'(a_d), hold);
    end
    step(1'b1, 1'b0, 8);
    step(1'b1, 1'b0, 8);
    chk("gap_rdy_end", int'(a_r), 1);
    chk("gap_dat", int'(a_d), 8);

    step(1'b1, 1'b0, 50);
    step(1'b1, 1'b1, 9);
    step(1'b1, 1'b0, 9);
    step(1'b1, 1'b0, 9);
    chk("sync_early", int'(a_r), 0);
    step(1'b1, 1'b0, 9);
    chk("sync_rdy", int'(a_r), 1);
    chk("sync_dat", int'(a_d), 9);

    step(1'b1, 1'b0, 77);
    step(1'b1, 1'b0, 77);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dat16", int'(a_d), 0);
    chk("rst_dat8", int'(s_d), 0);
    chk("rst_rdy", int'(a_r), 0);
    chk("rst_ovf", int'(s_o), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 20);
    chk("post_rst_rdy", int'(a_r), 1);
    chk("post_rst_dat", int'(a_d), 20);

    for (int i = 0; i < 10000; i++) begin
      e = $urandom_range(3) != 0;
      s = $urandom_range(31) == 0;
      m = int'($urandom_range(3));
      if (m == 0) d = int'($signed(16'($urandom)));
      else if (m == 1) d = int'($urandom_range(600)) - 300;
      else d = $urandom_range(1) ? 32767 : -32768;
      step(e, s, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
